// File: rtl/key_pkg.sv
// Shared types and helpers for the multi-channel key conditioner.
package key_pkg;

  // Per-channel debounce FSM state.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_st_t;

  // Convert a duration in milliseconds into a count of clock cycles.
  function automatic int unsigned cycles_from_ms(input int unsigned clk_hz,
                                                 input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_db_cell.sv
// One key channel: 2-FF synchroniser, integrating debounce FSM,
// one-cycle press/release pulses and, when KEY_LONG_PRESS_EN is
// defined, a one-shot long-press pulse. The input is already
// polarity-normalised (1 = pressed).
module key_db_cell
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 5
`ifdef KEY_LONG_PRESS_EN
  , parameter int unsigned LP_CYCLES = 20
`endif
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    key_p,
  output logic    key_state,
  output logic    key_press,
  output logic    key_release,
  output logic    key_long,
  output key_st_t dbg_state
);

  localparam int unsigned     DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  key_st_t         r_st;
  key_st_t         w_st_nxt;
  logic [DB_W-1:0] r_cnt;
  logic [DB_W-1:0] w_cnt_nxt;
  logic            r_key_state;
  logic            w_state_nxt;
  logic            r_press;
  logic            w_press_nxt;
  logic            r_release;
  logic            w_release_nxt;
  logic            w_p;

  // Two-stage synchroniser; resets to the released level so no press is seen at startup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= key_p;
      r_sync2 <= r_sync1;
    end
  end

  assign w_p = r_sync2;

  // Debounce next-state: a new level must persist for DB_CYCLES waiting cycles to be accepted.
  always_comb begin
    w_st_nxt      = r_st;
    w_cnt_nxt     = r_cnt;
    w_state_nxt   = r_key_state;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_st)
      IDLE: begin
        if (w_p) begin
          w_st_nxt  = PRESS_WAIT;
          w_cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_p) begin
          w_st_nxt  = IDLE;
          w_cnt_nxt = '0;
        end else if (r_cnt == DB_LAST) begin
          w_st_nxt    = PRESSED;
          w_cnt_nxt   = '0;
          w_state_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!w_p) begin
          w_st_nxt  = RELEASE_WAIT;
          w_cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_p) begin
          w_st_nxt  = PRESSED;
          w_cnt_nxt = '0;
        end else if (r_cnt == DB_LAST) begin
          w_st_nxt      = IDLE;
          w_cnt_nxt     = '0;
          w_state_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + DB_W'(1);
        end
      end
      default: begin
        w_st_nxt  = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st        <= IDLE;
      r_cnt       <= '0;
      r_key_state <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
    end else begin
      r_st        <= w_st_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_state <= w_state_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
    end
  end

  assign key_state   = r_key_state;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign dbg_state   = r_st;

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned     LP_W    = $clog2(LP_CYCLES + 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LP_CYCLES);

  logic [LP_W-1:0] r_lp_cnt;
  logic            r_flag_long;
  logic            r_long;

  // Hold timer: counts PRESSED cycles, survives release bounces, clears only on entry to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lp_cnt    <= '0;
      r_flag_long <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (w_st_nxt == IDLE) begin
        r_lp_cnt    <= '0;
        r_flag_long <= 1'b0;
      end else if (r_st == PRESSED) begin
        if (r_lp_cnt != LP_MAX) begin
          r_lp_cnt <= r_lp_cnt + LP_W'(1);
        end
        if ((r_lp_cnt == LP_LAST) && !r_flag_long) begin
          r_long      <= 1'b1;
          r_flag_long <= 1'b1;
        end
      end
    end
  end

  assign key_long = r_long;
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: polarity normalisation plus one
// key_db_cell per channel. Define KEY_LONG_PRESS_EN to enable the
// long-press pulse on key_long; otherwise key_long is tied low.
// dbg_state exposes each channel's FSM state (2 bits per channel).
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned CLK_HZ      = 12_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   key,
  output logic [N-1:0]   key_state,
  output logic [N-1:0]   key_press,
  output logic [N-1:0]   key_release,
  output logic [N-1:0]   key_long,
  output logic [2*N-1:0] dbg_state
);

  localparam int unsigned DB_CYCLES = cycles_from_ms(CLK_HZ, DEBOUNCE_MS);
`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned LP_CYCLES = cycles_from_ms(CLK_HZ, LONG_MS);
`endif

  logic [N-1:0] w_key_p;

  // Normalise so that 1 always means pressed, whatever the board wiring.
  assign w_key_p = ACTIVE_LOW ? ~key : key;

  for (genvar g = 0; g < N; g++) begin : g_ch
    key_st_t w_st;

    key_db_cell #(
      .DB_CYCLES (DB_CYCLES)
`ifdef KEY_LONG_PRESS_EN
      , .LP_CYCLES (LP_CYCLES)
`endif
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .key_p       (w_key_p[g]),
      .key_state   (key_state[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g]),
      .key_long    (key_long[g]),
      .dbg_state   (w_st)
    );

    assign dbg_state[2*g +: 2] = w_st;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: hand-written corner sequences, a
// table of phase vectors, and randomized key activity, all checked
// cycle by cycle against a level-integrating reference model.
module tb_key_debounce_multi;

  localparam int N  = 4;
  localparam int DB = 5;
  localparam int LP = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   key;
  logic [N-1:0]   key_state;
  logic [N-1:0]   key_press;
  logic [N-1:0]   key_release;
  logic [N-1:0]   key_long;
  logic [2*N-1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: a sample pipeline, the accepted level and the length of the
  // current run of samples that disagree with it.
  logic         m_s1 [N];
  logic         m_s2 [N];
  logic         m_acc [N];
  int           m_run [N];
  int           m_hold [N];
  logic         m_fired [N];
  logic [N-1:0] e_state, e_press, e_rel, e_long;
  logic [N-1:0] seen_press, seen_rel, seen_state;

  typedef struct {
    logic [3:0] pressed;
    int         cycles;
    logic [3:0] exp_state;
    logic [3:0] exp_press;
    logic [3:0] exp_rel;
  } vec_t;

  vec_t tbl [10];

  key_debounce_multi #(
    .N           (N),
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (5),
    .LONG_MS     (20),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .dbg_state   (dbg_state)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_acc[c] = 1'b0;
      m_run[c] = 0; m_hold[c] = 0; m_fired[c] = 1'b0;
    end
    e_state = '0; e_press = '0; e_rel = '0; e_long = '0;
  endtask

  // One clock edge of the model: accept a new level once the synchronised input has
  // disagreed with the accepted level on DB+1 consecutive edges.
  task automatic model_edge();
    if (!rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N; c++) begin
      logic p;
      p = m_s2[c];
      e_press[c] = 1'b0; e_rel[c] = 1'b0; e_long[c] = 1'b0;
`ifdef KEY_LONG_PRESS_EN
      if (m_acc[c] && m_run[c] == 0) begin
        if (m_hold[c] == LP - 1 && !m_fired[c]) begin
          e_long[c]  = 1'b1;
          m_fired[c] = 1'b1;
        end
        if (m_hold[c] < LP) m_hold[c]++;
      end
`endif
      if (p != m_acc[c]) m_run[c]++;
      else m_run[c] = 0;
      if (m_run[c] == DB + 1) begin
        m_acc[c] = p;
        m_run[c] = 0;
        if (p) e_press[c] = 1'b1;
        else begin
          e_rel[c]   = 1'b1;
          m_hold[c]  = 0;
          m_fired[c] = 1'b0;
        end
      end
      e_state[c] = m_acc[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = ~key[c];
    end
  endtask

  // Driver: advance one clock, update the model, compare #1 after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", key_state, e_state);
    chk("press", key_press, e_press);
    chk("release", key_release, e_rel);
    chk("long", key_long, e_long);
    seen_press |= key_press;
    seen_rel   |= key_release;
    seen_state |= key_state;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_seen();
    seen_press = '0; seen_rel = '0; seen_state = '0;
  endtask

  initial begin
    int lat;
    int n_long;
    int press_i;
    int long_i;

    tbl[0] = '{4'hF, 10, 4'hF, 4'hF, 4'h0};
    tbl[1] = '{4'h0, 10, 4'h0, 4'h0, 4'hF};
    tbl[2] = '{4'h5, 12, 4'h5, 4'h5, 4'h0};
    tbl[3] = '{4'h4, 3,  4'h5, 4'h0, 4'h0};
    tbl[4] = '{4'h5, 10, 4'h5, 4'h0, 4'h0};
    tbl[5] = '{4'h0, 10, 4'h0, 4'h0, 4'h5};
    tbl[6] = '{4'h8, 5,  4'h0, 4'h0, 4'h0};
    tbl[7] = '{4'h0, 10, 4'h0, 4'h0, 4'h0};
    tbl[8] = '{4'h8, 6,  4'h0, 4'h0, 4'h0};
    tbl[9] = '{4'h0, 12, 4'h0, 4'h8, 4'h8};

    rst = 1'b0;
    key = '1;
    model_reset();
    clr_seen();
    run(3);
    chk("reset_state", key_state, '0);
    chk("reset_press", key_press, '0);
    chk("reset_release", key_release, '0);
    chk("reset_long", key_long, '0);
    rst = 1'b1;
    run(4);

    // Clean press on ch0: pulse exactly 7 edges after the first sampling edge.
    clr_seen();
    key[0] = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (key_press[0]) begin
        lat = i;
        break;
      end
    end
    chk_int("t1_press_latency", lat, 7);
    step();
    chk("t1_pulse_width", key_press, 4'h0);
    chk("t1_state_held", key_state, 4'h1);

    // ch1 bounce shorter than the debounce window.
    clr_seen();
    key[1] = 1'b0; run(3);
    key[1] = 1'b1; run(2);
    key[1] = 1'b0; run(3);
    key[1] = 1'b1; run(10);
    chk("t2_no_press", seen_press & 4'h2, 4'h0);
    chk("t2_no_release", seen_rel & 4'h2, 4'h0);
    chk("t2_state_low", seen_state & 4'h2, 4'h0);

    // ch2 press for 10 clk, then clean release.
    key[2] = 1'b0;
    run(10);
    key[2] = 1'b1;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (key_release[2]) begin
        lat = i;
        break;
      end
    end
    chk_int("t3_release_latency", lat, 7);
    chk("t3_state_low", key_state & 4'h4, 4'h0);
    key[0] = 1'b1;
    run(12);

    // All four keys together.
    key = '0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (|key_press) begin
        lat = i;
        break;
      end
    end
    chk("t4_press_all", key_press, 4'hF);
    run(5);
    key = '1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (|key_release) break;
    end
    chk("t4_release_all", key_release, 4'hF);
    run(5);

    // Table of phase vectors.
    for (int v = 0; v < 10; v++) begin
      key = ~tbl[v].pressed;
      clr_seen();
      run(tbl[v].cycles);
      chk($sformatf("tbl%0d_state", v), key_state, tbl[v].exp_state);
      chk($sformatf("tbl%0d_press", v), seen_press, tbl[v].exp_press);
      chk($sformatf("tbl%0d_release", v), seen_rel, tbl[v].exp_rel);
    end

    // Long hold on ch3.
    key[3] = 1'b0;
    n_long = 0; press_i = -1; long_i = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (key_press[3]) press_i = i;
      if (key_long[3]) begin
        n_long++;
        long_i = i;
      end
    end
    key[3] = 1'b1;
    clr_seen();
    run(12);
    chk("t5_release_after_long", seen_rel, 4'h8);
`ifdef KEY_LONG_PRESS_EN
    chk_int("t5_long_count", n_long, 1);
    chk_int("t5_long_delay", long_i - press_i, 20);
`else
    chk_int("t5_long_count", n_long, 0);
`endif

    // Reset while ch0 is held.
    key[0] = 1'b0;
    run(10);
    chk("t6_pressed_before", key_state, 4'h1);
    clr_seen();
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("t6_async_state", key_state, '0);
    chk("t6_async_press", key_press, '0);
    chk("t6_async_release", key_release, '0);
    chk("t6_async_long", key_long, '0);
    run(3);
    rst = 1'b1;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (key_press[0]) begin
        lat = i;
        break;
      end
    end
    chk_int("t6_repress_latency", lat, 7);
    chk("t6_no_release", seen_rel, 4'h0);
    key = '1;
    run(12);

    // Randomized key activity against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 7) == 0) key[c] = ~key[c];
      end
      step();
    end
    key = '1;
    run(20);
    chk("final_state", key_state, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
